// File: rtl/arb_types.sv
// ----------------------------------------------------------------------------
// arb_types
// Shared types and constants for the I/D cache line-port arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester received the most recent grant
//   DEF_LINE_W  : default cache line width in bits
//   DEF_OFFSET_W: default byte-offset width cleared on memory addresses
//   line_align  : clears the byte-offset bits of a line address
// ----------------------------------------------------------------------------
package arb_types;

   localparam int DEF_LINE_W   = 256;
   localparam int DEF_OFFSET_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RESP_I,
      RESP_D
   } arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_t;

   function automatic logic [31:0] line_align(input logic [31:0] addr,
                                              input int unsigned off_w);
      return addr & ~((32'h1 << off_w) - 32'h1);
   endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// ----------------------------------------------------------------------------
// cache_arbiter_if
// Bundles the I-cache miss port, the D-cache miss port and the physical
// memory line port seen by cache_arbiter.
//   slave  : the arbiter's view (takes cache requests and memory
//            completions, drives cache responses and memory commands)
//   master : the surrounding system's view (caches plus memory)
// ----------------------------------------------------------------------------
interface cache_arbiter_if
   import arb_types::*;
#(
   parameter int LINE_W = DEF_LINE_W
);
   // I-cache side
   logic              i_read;
   logic [31:0]       i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   // D-cache side
   logic              d_read;
   logic              d_write;
   logic [31:0]       d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   // memory side
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_resp;

   modport slave (
      input  i_read, i_addr, d_read, d_write, d_addr, d_wdata,
             mem_rdata, mem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output i_read, i_addr, d_read, d_write, d_addr, d_wdata,
             mem_rdata, mem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface

// File: rtl/cache_arbiter.sv
// ----------------------------------------------------------------------------
// cache_arbiter
// Serializes I-cache line fills and D-cache fills/write-backs onto a single
// memory line port. The winning request is latched on the grant edge and
// presented to memory from registers until mem_resp; the requester then sees
// a one-cycle response pulse with the line register on its rdata bus.
// Simultaneous requests alternate, data side first after reset.
// Ports:
//   clk - clock, all state on the rising edge
//   rst - asynchronous active-low reset
//   bus - cache_arbiter_if.slave: I/D cache miss ports and memory line port
// ----------------------------------------------------------------------------
module cache_arbiter
   import arb_types::*;
#(
   parameter int LINE_W   = DEF_LINE_W,
   parameter int OFFSET_W = DEF_OFFSET_W
) (
   input  logic           clk,
   input  logic           rst,
   cache_arbiter_if.slave bus
);

   arb_state_t        r_state;
   grant_t            r_last_grant;
   logic              r_mem_read;
   logic              r_mem_write;
   logic [31:0]       r_addr;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_line;
   logic              r_i_resp;
   logic              r_d_resp;

   logic w_i_pend;
   logic w_d_pend;
   logic w_pick_d;
   logic w_d_is_write;

   assign w_i_pend     = bus.i_read;
   assign w_d_pend     = bus.d_read | bus.d_write;
   // A write-back must land before the refill that follows it, so a
   // simultaneous read+write from the D-cache is executed as the write.
   assign w_d_is_write = bus.d_write;
   // D wins when alone, or on a tie when I was granted last.
   assign w_pick_d     = w_d_pend & (~w_i_pend | (r_last_grant == GRANT_I));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_last_grant <= GRANT_I;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_line       <= '0;
         r_i_resp     <= 1'b0;
         r_d_resp     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_d) begin
                  r_state      <= BUSY_D;
                  r_last_grant <= GRANT_D;
                  r_addr       <= line_align(bus.d_addr, OFFSET_W);
                  r_mem_read   <= ~w_d_is_write;
                  r_mem_write  <= w_d_is_write;
                  if (w_d_is_write) begin
                     r_wdata <= bus.d_wdata;
                  end
               end else if (w_i_pend) begin
                  r_state      <= BUSY_I;
                  r_last_grant <= GRANT_I;
                  r_addr       <= line_align(bus.i_addr, OFFSET_W);
                  r_mem_read   <= 1'b1;
                  r_mem_write  <= 1'b0;
               end
            end
            BUSY_I, BUSY_D: begin
               if (bus.mem_resp) begin
                  // Write completions leave the line register untouched.
                  if (r_mem_read) begin
                     r_line <= bus.mem_rdata;
                  end
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  if (r_state == BUSY_D) begin
                     r_state  <= RESP_D;
                     r_d_resp <= 1'b1;
                  end else begin
                     r_state  <= RESP_I;
                     r_i_resp <= 1'b1;
                  end
               end
            end
            RESP_I, RESP_D: begin
               r_i_resp <= 1'b0;
               r_d_resp <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_read  = r_mem_read;
   assign bus.mem_write = r_mem_write;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.i_rdata   = r_line;
   assign bus.d_rdata   = r_line;
   assign bus.i_resp    = r_i_resp;
   assign bus.d_resp    = r_d_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cache_arbiter
// Directed bench for cache_arbiter: the bench plays both caches and the
// memory, drives inputs and samples outputs on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_cache_arbiter;
   import arb_types::*;

   localparam int LW = 256;
   localparam logic [LW-1:0] L_A5 = {32{8'hA5}};
   localparam logic [LW-1:0] L_3C = {32{8'h3C}};
   localparam logic [LW-1:0] L_D1 = {32{8'hD1}};
   localparam logic [LW-1:0] L_I1 = {32{8'h11}};
   localparam logic [LW-1:0] L_D2 = {32{8'hD2}};
   localparam logic [LW-1:0] L_RG = {32{8'h5A}};
   localparam logic [LW-1:0] L_FF = {32{8'hFF}};
   localparam logic [LW-1:0] L_EE = {32{8'hEE}};
   localparam logic [LW-1:0] W_1  = {8{32'h1234_5678}};
   localparam logic [LW-1:0] W_2  = {8{32'hCAFE_F00D}};
   localparam logic [LW-1:0] W_3  = {8{32'h0BAD_BEEF}};

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   cache_arbiter_if #(.LINE_W(LW)) bus ();

   cache_arbiter #(.LINE_W(LW), .OFFSET_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LW-1:0] got,
                        input logic [LW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Called at the falling edge of the first busy cycle. Checks the memory
   // command each busy cycle, returns mem_resp in busy cycle nbusy, then
   // checks the response cycle. Returns at the falling edge of that cycle.
   task automatic serve(input string tag, input bit exp_d, input bit exp_wr,
                        input logic [31:0] exp_addr, input logic [LW-1:0] exp_wdata,
                        input int nbusy, input logic [LW-1:0] rd_line,
                        input logic [LW-1:0] exp_line);
      for (int c = 1; c <= nbusy; c++) begin
         check($sformatf("%s.mem_read[%0d]", tag, c), LW'(bus.mem_read), LW'(!exp_wr));
         check($sformatf("%s.mem_write[%0d]", tag, c), LW'(bus.mem_write), LW'(exp_wr));
         check($sformatf("%s.mem_addr[%0d]", tag, c), LW'(bus.mem_addr), LW'(exp_addr));
         if (exp_wr) begin
            check($sformatf("%s.mem_wdata[%0d]", tag, c), bus.mem_wdata, exp_wdata);
         end
         check($sformatf("%s.early_resp[%0d]", tag, c),
               LW'({bus.i_resp, bus.d_resp}), LW'(2'b00));
         if (c == nbusy) begin
            bus.mem_resp  = 1'b1;
            bus.mem_rdata = rd_line;
         end
         @(negedge clk);
      end
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      check($sformatf("%s.i_resp", tag), LW'(bus.i_resp), LW'(!exp_d));
      check($sformatf("%s.d_resp", tag), LW'(bus.d_resp), LW'(exp_d));
      check($sformatf("%s.rdata", tag), exp_d ? bus.d_rdata : bus.i_rdata, exp_line);
      check($sformatf("%s.mem_cmd_off", tag),
            LW'({bus.mem_read, bus.mem_write}), LW'(2'b00));
      $display("txn %-10s side=%s op=%s addr=%h busy=%0d",
               tag, exp_d ? "D" : "I", exp_wr ? "WR" : "RD", exp_addr, nbusy);
   endtask

   // One cycle after a response: back in IDLE with nothing driven.
   task automatic check_idle(input string tag);
      check($sformatf("%s.idle_cmd", tag), LW'({bus.mem_read, bus.mem_write}), LW'(2'b00));
      check($sformatf("%s.idle_resp", tag), LW'({bus.i_resp, bus.d_resp}), LW'(2'b00));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] t_word;
      bit          t_d;

      rst           = 1'b0;
      bus.i_read    = 1'b0;
      bus.i_addr    = '0;
      bus.d_read    = 1'b0;
      bus.d_write   = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.mem_rdata = '0;
      bus.mem_resp  = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst.cmd", LW'({bus.mem_read, bus.mem_write}), LW'(2'b00));
      check("rst.resp", LW'({bus.i_resp, bus.d_resp}), LW'(2'b00));
      check("rst.mem_addr", LW'(bus.mem_addr), '0);
      check("rst.mem_wdata", bus.mem_wdata, '0);
      check("rst.i_rdata", bus.i_rdata, '0);
      check("rst.d_rdata", bus.d_rdata, '0);
      rst = 1'b1;
      @(negedge clk);

      // I-only read, memory answers in the 4th busy cycle
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_0064;
      @(negedge clk);
      serve("i_only", 1'b0, 1'b0, 32'h0000_0060, '0, 4, L_A5, L_A5);
      bus.i_read = 1'b0;
      @(negedge clk);
      check_idle("i_only");

      // D write-back; requester inputs change while busy and must be ignored
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h8000_001F;
      bus.d_wdata = W_1;
      @(negedge clk);
      bus.d_wdata = '1;
      bus.d_addr  = 32'h0000_0000;
      serve("d_wb", 1'b1, 1'b1, 32'h8000_0000, W_1, 3, L_3C, L_A5);
      bus.d_write = 1'b0;
      @(negedge clk);
      check_idle("d_wb");

      // Tie after reset: D first, then I, then the next tie goes to D
      do_reset();
      bus.i_read = 1'b1;
      bus.i_addr = 32'h1000_0040;
      bus.d_read = 1'b1;
      bus.d_addr = 32'h2000_0033;
      @(negedge clk);
      serve("tie_d", 1'b1, 1'b0, 32'h2000_0020, '0, 1, L_D1, L_D1);
      bus.d_read = 1'b0;
      @(negedge clk);
      check_idle("tie_d");
      @(negedge clk);
      serve("tie_i", 1'b0, 1'b0, 32'h1000_0040, '0, 2, L_I1, L_I1);
      bus.i_read = 1'b0;
      @(negedge clk);
      check_idle("tie_i");
      bus.i_read = 1'b1;
      bus.d_read = 1'b1;
      @(negedge clk);
      serve("tie2_d", 1'b1, 1'b0, 32'h2000_0020, '0, 1, L_D2, L_D2);
      bus.i_read = 1'b0;
      bus.d_read = 1'b0;
      @(negedge clk);
      check_idle("tie2");

      // Continuous contention: D,I,D,I,D,I with one IDLE cycle between
      do_reset();
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_1000;
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_2000;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         t_d    = (t % 2 == 0);
         t_word = 32'hC000_0000 + 32'(t);
         serve($sformatf("cont%0d", t), t_d, 1'b0,
               t_d ? 32'h0000_2000 : 32'h0000_1000, '0,
               1 + (t % 3), {8{t_word}}, {8{t_word}});
         if (t == 5) begin
            bus.i_read = 1'b0;
            bus.d_read = 1'b0;
         end
         @(negedge clk);
         check_idle($sformatf("cont%0d", t));
      end

      // Reset in the middle of a D write-back
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h4000_0008;
      bus.d_wdata = W_2;
      @(negedge clk);
      check("rstmid.mem_write_before", LW'(bus.mem_write), LW'(1'b1));
      rst         = 1'b0;
      bus.d_write = 1'b0;
      bus.d_read  = 1'b1;
      #1;
      check("rstmid.mem_write_async", LW'(bus.mem_write), LW'(1'b0));
      check("rstmid.mem_addr_async", LW'(bus.mem_addr), '0);
      check("rstmid.d_rdata_async", bus.d_rdata, '0);
      @(negedge clk);
      @(negedge clk);
      check("rstmid.held_cmd", LW'({bus.mem_read, bus.mem_write}), LW'(2'b00));
      check("rstmid.no_resp", LW'(bus.d_resp), LW'(1'b0));
      rst = 1'b1;
      @(negedge clk);
      serve("rst_regrant", 1'b1, 1'b0, 32'h4000_0000, '0, 2, L_RG, L_RG);
      bus.d_read = 1'b0;
      @(negedge clk);
      check_idle("rst_regrant");

      // Stray mem_resp in IDLE is ignored and does not load the line
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = L_FF;
      @(negedge clk);
      check_idle("stray1");
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = '0;
      @(negedge clk);
      check_idle("stray2");
      check("stray.line_kept", bus.i_rdata, L_RG);

      // d_read and d_write together execute as a write-back
      bus.d_read  = 1'b1;
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h0000_0ABC;
      bus.d_wdata = W_3;
      @(negedge clk);
      serve("dual", 1'b1, 1'b1, 32'h0000_0AA0, W_3, 2, L_EE, L_RG);
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      @(negedge clk);
      check_idle("dual");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
